// File: rtl/reg_file_wb.sv
// reg_file_wb: register file feeding the ALU operand buses, capturing write-back, with a handshaked dump port.
// Ports:
//   CLK, RESET (async, active-low)
//   IN, INADDRESS, WRITE, ZERO_IN      : write-back from the ALU
//   OUT1ADDRESS/OUT1, OUT2ADDRESS/OUT2 : combinational operand reads
//   ZERO_FLAG                          : ZERO status of the last write-back
//   DUMP_REQ, DUMP_READY               : dump request / beat accept
//   DUMP_VALID, DUMP_ADDR, DUMP_DATA   : current dump beat
//   DUMP_BUSY, DUMP_DONE               : scan in progress / end-of-dump pulse
module reg_file_wb #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic              ZERO_IN,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic              ZERO_FLAG,
    input  logic              DUMP_REQ,
    input  logic              DUMP_READY,
    output logic              DUMP_VALID,
    output logic [ADDR_W-1:0] DUMP_ADDR,
    output logic [WIDTH-1:0]  DUMP_DATA,
    output logic              DUMP_BUSY,
    output logic              DUMP_DONE
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] nxt_addr;
    logic [WIDTH-1:0] nxt_data;
    always_comb begin
        OUT1 = (BYPASS != 0 && WRITE && OUT1ADDRESS == INADDRESS) ? IN : mem[OUT1ADDRESS];
        OUT2 = (BYPASS != 0 && WRITE && OUT2ADDRESS == INADDRESS) ? IN : mem[OUT2ADDRESS];
        nxt_addr = (state == IDLE) ? '0 : DUMP_ADDR + 1'b1;
        // The dump always captures the post-edge register value, so a coincident write is forwarded.
        nxt_data = (WRITE && INADDRESS == nxt_addr) ? IN : mem[nxt_addr];
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ZERO_FLAG <= 1'b0;
        end else if (WRITE) begin
            mem[INADDRESS] <= IN;
            ZERO_FLAG <= ZERO_IN;
        end
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            DUMP_VALID <= 1'b0;
            DUMP_BUSY <= 1'b0;
            DUMP_DONE <= 1'b0;
            DUMP_ADDR <= '0;
            DUMP_DATA <= '0;
        end else begin
            case (state)
                IDLE: if (DUMP_REQ) begin
                    state <= SCAN;
                    DUMP_VALID <= 1'b1;
                    DUMP_BUSY <= 1'b1;
                    DUMP_ADDR <= nxt_addr;
                    DUMP_DATA <= nxt_data;
                end
                SCAN: if (DUMP_READY) begin
                    if (DUMP_ADDR == LAST) begin
                        state <= DONE;
                        DUMP_VALID <= 1'b0;
                        DUMP_BUSY <= 1'b0;
                        DUMP_DONE <= 1'b1;
                    end else begin
                        DUMP_ADDR <= nxt_addr;
                        DUMP_DATA <= nxt_data;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    DUMP_DONE <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: randomized self-checking bench for reg_file_wb (BYPASS=1 and BYPASS=0 instances).
module tb_reg_file_wb;
    logic       CLK = 0;
    logic       RESET = 0;
    logic [7:0] IN = 0;
    logic [2:0] INADDRESS = 0, OUT1ADDRESS = 0, OUT2ADDRESS = 0;
    logic       WRITE = 0, ZERO_IN = 0, DUMP_REQ = 0, DUMP_READY = 0;
    logic [7:0] o1, o2, dd, o1n, o2n, ddn;
    logic [2:0] da, dan;
    logic       zf, dv, db, dn, zfn, dvn, dbn, dnn;
    int total = 0, bad = 0;
    logic [7:0] model [8];
    logic       mzf;

    always #5 CLK = ~CLK;

    reg_file_wb #(.BYPASS(1)) dut (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE), .ZERO_IN(ZERO_IN),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(o1), .OUT2(o2), .ZERO_FLAG(zf),
        .DUMP_REQ(DUMP_REQ), .DUMP_READY(DUMP_READY), .DUMP_VALID(dv), .DUMP_ADDR(da), .DUMP_DATA(dd),
        .DUMP_BUSY(db), .DUMP_DONE(dn));

    reg_file_wb #(.BYPASS(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE), .ZERO_IN(ZERO_IN),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(o1n), .OUT2(o2n), .ZERO_FLAG(zfn),
        .DUMP_REQ(DUMP_REQ), .DUMP_READY(DUMP_READY), .DUMP_VALID(dvn), .DUMP_ADDR(dan), .DUMP_DATA(ddn),
        .DUMP_BUSY(dbn), .DUMP_DONE(dnn));

    // One clock edge; the reference model commits the write that the edge performs.
    task automatic cyc();
        @(posedge CLK);
        if (RESET && WRITE) begin
            model[INADDRESS] = IN;
            mzf = ZERO_IN;
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic z);
        WRITE = 1; INADDRESS = a; IN = d; ZERO_IN = z;
        cyc();
        WRITE = 0;
    endtask

    task automatic test_reset();
        RESET = 0; WRITE = 1; INADDRESS = 3; IN = 8'hA5;
        for (int i = 0; i < 8; i++) model[i] = 0;
        mzf = 0;
        cyc(); cyc();
        WRITE = 0;
        #2 RESET = 1;
        OUT1ADDRESS = 3; OUT2ADDRESS = 7;
        #1;
        total++; if (o1 !== 8'h00 || o2 !== 8'h00) begin bad++; $display("FAIL reset_read got %h/%h want 00/00", o1, o2); end
        total++; if (zf !== 1'b0) begin bad++; $display("FAIL reset_zero got %b want 0", zf); end
        total++; if ({dv, db, dn, da, dd} !== 14'd0) begin bad++; $display("FAIL reset_dump got v%b b%b d%b a%h d%h want all 0", dv, db, dn, da, dd); end
    endtask

    task automatic test_write_read();
        wr(2, 8'h5A, 0);
        wr(5, 8'h00, 1);
        OUT1ADDRESS = 2; OUT2ADDRESS = 5;
        #1;
        total++; if (o1 !== 8'h5A || o2 !== 8'h00) begin bad++; $display("FAIL wr_readback got %h/%h want 5a/00", o1, o2); end
        total++; if (zf !== 1'b1) begin bad++; $display("FAIL wr_zero got %b want 1", zf); end
        for (int n = 0; n < 60; n++) begin
            logic [7:0] e1, e2;
            WRITE = 1'($urandom % 2); INADDRESS = 3'($urandom); IN = 8'($urandom); ZERO_IN = 1'($urandom);
            OUT1ADDRESS = 3'($urandom); OUT2ADDRESS = (n % 5 == 0) ? OUT1ADDRESS : 3'($urandom);
            #1;
            e1 = (WRITE && OUT1ADDRESS == INADDRESS) ? IN : model[OUT1ADDRESS];
            e2 = (WRITE && OUT2ADDRESS == INADDRESS) ? IN : model[OUT2ADDRESS];
            total++; if (o1 !== e1 || o2 !== e2) begin bad++; $display("FAIL rnd_byp n=%0d got %h/%h want %h/%h", n, o1, o2, e1, e2); end
            total++; if (o1n !== model[OUT1ADDRESS] || o2n !== model[OUT2ADDRESS]) begin bad++; $display("FAIL rnd_nobyp n=%0d got %h/%h want %h/%h", n, o1n, o2n, model[OUT1ADDRESS], model[OUT2ADDRESS]); end
            cyc();
            total++; if (zf !== mzf || zfn !== mzf) begin bad++; $display("FAIL rnd_zero n=%0d got %b/%b want %b", n, zf, zfn, mzf); end
        end
        WRITE = 0;
    endtask

    task automatic test_bypass();
        wr(4, 8'h11, 0);
        WRITE = 1; INADDRESS = 4; IN = 8'h22; OUT1ADDRESS = 4;
        #1;
        total++; if (o1 !== 8'h22) begin bad++; $display("FAIL bypass_on got %h want 22", o1); end
        total++; if (o1n !== 8'h11) begin bad++; $display("FAIL bypass_off_pre got %h want 11", o1n); end
        cyc();
        WRITE = 0;
        #1;
        total++; if (o1n !== 8'h22) begin bad++; $display("FAIL bypass_off_post got %h want 22", o1n); end
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i), 0);
    endtask

    task automatic test_full_dump();
        load_pattern();
        DUMP_READY = 1; DUMP_REQ = 1;
        cyc();
        DUMP_REQ = 0;
        for (int i = 0; i < 8; i++) begin
            total++; if (dv !== 1 || db !== 1 || da !== 3'(i) || dd !== 8'(8'h10 + i)) begin bad++; $display("FAIL full_beat%0d got v%b b%b a%0d d%h want v1 b1 a%0d d%h", i, dv, db, da, dd, i, 8'h10 + i); end
            cyc();
        end
        total++; if (dn !== 1 || db !== 0 || dv !== 0) begin bad++; $display("FAIL full_done got d%b b%b v%b want d1 b0 v0", dn, db, dv); end
        cyc();
        total++; if (dn !== 0) begin bad++; $display("FAIL full_done_pulse got %b want 0", dn); end
    endtask

    task automatic test_stall();
        int k;
        DUMP_READY = 1; DUMP_REQ = 1;
        cyc();
        DUMP_REQ = 0;
        k = 0;
        while (da !== 3'd3 && k < 20) begin cyc(); k++; end
        total++; if (da !== 3'd3) begin bad++; $display("FAIL stall_reach got a%0d want 3", da); end
        DUMP_READY = 0; WRITE = 1; INADDRESS = 3; IN = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (da !== 3'd3 || dd !== 8'h13 || dv !== 1) begin bad++; $display("FAIL stall_hold%0d got a%0d d%h v%b want a3 d13 v1", i, da, dd, dv); end
        end
        WRITE = 0; DUMP_READY = 1;
        cyc();
        total++; if (da !== 3'd4 || dd !== 8'h14) begin bad++; $display("FAIL stall_release got a%0d d%h want a4 d14", da, dd); end
        OUT1ADDRESS = 3;
        #1;
        total++; if (o1 !== 8'hFF) begin bad++; $display("FAIL stall_r3 got %h want ff", o1); end
        k = 0;
        while (dn !== 1 && k < 20) begin cyc(); k++; end
        total++; if (dn !== 1) begin bad++; $display("FAIL stall_finish got done=%b want 1", dn); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int k;
        DUMP_READY = 1; DUMP_REQ = 1;
        cyc();
        DUMP_REQ = 0;
        k = 0;
        while (da !== 3'd5 && k < 20) begin cyc(); k++; end
        #2 RESET = 0;
        for (int i = 0; i < 8; i++) model[i] = 0;
        mzf = 0;
        #1;
        total++; if ({dv, db, dn, da, dd} !== 14'd0) begin bad++; $display("FAIL rstmid_dump got v%b b%b d%b a%h d%h want all 0", dv, db, dn, da, dd); end
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(7 - a);
            #1;
            total++; if (o1 !== 0 || o2 !== 0) begin bad++; $display("FAIL rstmid_reg%0d got %h/%h want 00/00", a, o1, o2); end
        end
        cyc();
        RESET = 1; DUMP_REQ = 1;
        cyc();
        DUMP_REQ = 0;
        total++; if (dv !== 1 || da !== 3'd0 || dd !== 8'h00) begin bad++; $display("FAIL rstmid_restart got v%b a%0d d%h want v1 a0 d00", dv, da, dd); end
        k = 0;
        while (dn !== 1 && k < 20) begin cyc(); k++; end
        cyc();
    endtask

    // Random READY, random writes and stray requests during the scan; the first beat is written in the same edge.
    task automatic test_back_to_back();
        int b;
        logic [7:0] exp;
        logic fin, rd;
        for (int i = 0; i < 8; i++) wr(3'(i), 8'($urandom), 0);
        DUMP_REQ = 1; WRITE = 1; INADDRESS = 0; IN = 8'($urandom);
        cyc();
        DUMP_REQ = 0;
        b = 0; exp = model[0]; fin = 0;
        total++; if (dv !== 1 || da !== 3'd0 || dd !== exp) begin bad++; $display("FAIL b2b_first got a%0d d%h want a0 d%h", da, dd, exp); end
        for (int n = 0; n < 200 && !fin; n++) begin
            rd = 1'($urandom % 2);
            DUMP_READY = rd; DUMP_REQ = 1'($urandom % 2);
            WRITE = 1'($urandom % 2); INADDRESS = 3'($urandom); IN = 8'($urandom);
            cyc();
            if (rd) begin
                if (b == 7) fin = 1;
                else begin b++; exp = model[b]; end
            end
            if (fin) begin
                total++; if (dn !== 1 || dv !== 0) begin bad++; $display("FAIL b2b_done got d%b v%b want d1 v0", dn, dv); end
            end else begin
                total++; if (dv !== 1 || da !== 3'(b) || dd !== exp) begin bad++; $display("FAIL b2b_beat n=%0d got a%0d d%h want a%0d d%h", n, da, dd, b, exp); end
            end
        end
        if (!fin) begin total++; bad++; $display("FAIL b2b_timeout got beat %0d want done", b); end
        WRITE = 0; DUMP_REQ = 1;
        cyc();
        DUMP_REQ = 0;
        cyc();
        total++; if (dv !== 0 || db !== 0 || dn !== 0) begin bad++; $display("FAIL b2b_req_in_done got v%b b%b d%b want 0", dv, db, dn); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_full_dump();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
